adaptive_booth_mul32: RTL and testbench

//   Iterative 32x32 signed multiplier, radix-4 Booth, 64-bit product. Consumes
//   lzc32 leading-bit counts of both operands to cut iterations (early termination).

---
 rtl/adaptive_booth_mul32.sv | 143 ++++++++++++++
 tb/tb_adaptive_booth_mul32.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/adaptive_booth_mul32.sv
// Iterative 32x32 signed radix-4 Booth multiplier with carry-save accumulation
// and early termination driven by the redundant-sign-bit count of the multiplier.

module lzc32 (
   input  logic [31:0] x,
   output logic [4:0]  cnt
);
   // Counts leading bits below the MSB that equal the sign bit (0 and -1 give 31).
   logic [30:0] diff;

   assign diff = x[30:0] ^ x[31:1];

   always_comb begin
      cnt = 5'd31;
      for (int k = 0; k <= 30; k++)
         if (diff[k]) cnt = 5'(30 - k);
   end
endmodule

module csa_3_2 #(
   parameter int WIDTH = 64
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] c,
   input  logic             cin,
   output logic [WIDTH-1:0] s,
   output logic [WIDTH-1:0] cy
);
   assign s  = a ^ b ^ c;
   assign cy = {(a[WIDTH-2:0] & b[WIDTH-2:0]) | (a[WIDTH-2:0] & c[WIDTH-2:0]) |
                (b[WIDTH-2:0] & c[WIDTH-2:0]), cin};
endmodule

module adaptive_booth_mul32 #(
   parameter bit EARLY_TERM = 1'b1,
   parameter bit SWAP_EN    = 1'b1
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_a,
   input  logic [31:0] in_b,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [63:0] out_prod,
   output logic [4:0]  out_iters
);
   typedef enum logic [1:0] {IDLE, ITER, RESOLVE, DONE} state_t;

   state_t      state;
   logic [4:0]  la, lb, l_sel, n_in;
   logic        swap;
   logic [31:0] mcand_q, mplier_q;
   logic [4:0]  n_q;
   logic [3:0]  i_q;
   logic [63:0] acc_s, acc_c, csa_s, csa_c;
   logic [32:0] mx;
   logic [2:0]  trip;
   logic [5:0]  shamt;
   logic [63:0] mc64, sel, pp;
   logic        neg;

   lzc32 u_lzc_a (.x(in_a), .cnt(la));
   lzc32 u_lzc_b (.x(in_b), .cnt(lb));

   assign swap  = SWAP_EN && (la > lb);
   assign l_sel = swap ? la : lb;
   assign n_in  = EARLY_TERM ? 5'((6'd33 - {1'b0, l_sel}) >> 1) : 5'd16;

   assign mx    = {mplier_q, 1'b0};
   assign trip  = mx[{1'b0, i_q, 1'b0} +: 3];
   assign shamt = {1'b0, i_q, 1'b0};
   assign mc64  = {{32{mcand_q[31]}}, mcand_q};

   always_comb begin
      sel = 64'd0;
      neg = 1'b0;
      case (trip)
         3'b001, 3'b010: sel = mc64;
         3'b011:         sel = mc64 << 1;
         3'b100:         begin sel = mc64 << 1; neg = 1'b1; end
         3'b101, 3'b110: begin sel = mc64;      neg = 1'b1; end
         default:        sel = 64'd0;
      endcase
   end

   // Inverting after the shift fills the low 2i bits with ones, so the +1 of the
   // two's complement lands at bit 0, which the CSA carry vector always leaves free.
   assign pp = neg ? ~(sel << shamt) : (sel << shamt);

   csa_3_2 #(.WIDTH(64)) u_csa (
      .a(acc_s), .b(acc_c), .c(pp), .cin(neg), .s(csa_s), .cy(csa_c)
   );

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         out_prod  <= 64'd0;
         out_iters <= 5'd0;
         acc_s     <= 64'd0;
         acc_c     <= 64'd0;
         mcand_q   <= 32'd0;
         mplier_q  <= 32'd0;
         n_q       <= 5'd0;
         i_q       <= 4'd0;
      end else begin
         case (state)
            IDLE: if (in_valid && in_ready) begin
               mcand_q  <= swap ? in_b : in_a;
               mplier_q <= swap ? in_a : in_b;
               n_q      <= n_in;
               i_q      <= 4'd0;
               acc_s    <= 64'd0;
               acc_c    <= 64'd0;
               in_ready <= 1'b0;
               state    <= ITER;
            end
            ITER: begin
               acc_s <= csa_s;
               acc_c <= csa_c;
               i_q   <= i_q + 4'd1;
               if ({1'b0, i_q} == n_q - 5'd1) state <= RESOLVE;
            end
            RESOLVE: begin
               out_prod  <= acc_s + acc_c;
               out_iters <= n_q;
               out_valid <= 1'b1;
               state     <= DONE;
            end
            DONE: if (out_ready) begin
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_adaptive_booth_mul32.sv
// Bench for adaptive_booth_mul32: random operands against a plain a*b model with
// iteration counts from the minimum signed width of the narrower operand.

module tb_adaptive_booth_mul32;
   logic        clk = 1'b0;
   logic        resetn = 1'b1;
   logic        in_valid = 1'b0, out_ready = 1'b0;
   logic        in_valid0 = 1'b0, out_ready0 = 1'b0;
   logic [31:0] in_a = 32'd0, in_b = 32'd0;
   logic        in_ready, out_valid, in_ready0, out_valid0;
   logic [63:0] out_prod, out_prod0;
   logic [4:0]  out_iters, out_iters0;

   int total = 0;
   int bad = 0;
   int cyc = 0;

   typedef struct {
      logic [63:0] prod;
      logic [4:0]  iters;
      int          e0;
   } exp_t;

   exp_t q[$];
   bit   seen = 1'b0;

   adaptive_booth_mul32 dut (
      .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
      .out_prod(out_prod), .out_iters(out_iters)
   );

   adaptive_booth_mul32 #(.EARLY_TERM(1'b0)) dut0 (
      .clk(clk), .resetn(resetn), .in_valid(in_valid0), .in_ready(in_ready0),
      .in_a(in_a), .in_b(in_b), .out_valid(out_valid0), .out_ready(out_ready0),
      .out_prod(out_prod0), .out_iters(out_iters0)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc = cyc + 1;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Smallest w such that x is representable as a w-bit two's complement value.
   function automatic int minw(input logic [31:0] x);
      longint v = longint'($signed(x));
      for (int w = 1; w <= 32; w++) begin
         longint lo = -(longint'(1) << (w - 1));
         longint hi = (longint'(1) << (w - 1)) - 1;
         if (v >= lo && v <= hi) return w;
      end
      return 32;
   endfunction

   function automatic int model_n(input logic [31:0] a, input logic [31:0] b, input bit et);
      int w;
      if (!et) return 16;
      w = (minw(a) < minw(b)) ? minw(a) : minw(b);
      return (w + 1) / 2;
   endfunction

   function automatic logic [63:0] model_prod(input logic [31:0] a, input logic [31:0] b);
      return longint'($signed(a)) * longint'($signed(b));
   endfunction

   function automatic logic [31:0] rnd_op();
      logic [31:0] x = $urandom;
      int sh = $urandom_range(0, 31);
      return $signed(x) >>> sh;
   endfunction

   // Output checker: every cycle out_valid is high it must match the head of the model queue.
   always @(negedge clk) begin
      if (resetn && out_valid) begin
         if (q.size() == 0) begin
            chk("spurious_valid", 64'(out_valid), 64'd0);
         end else begin
            if (!seen) begin
               chk("latency", 64'(cyc), 64'(q[0].e0 + int'(q[0].iters) + 1));
               seen = 1'b1;
            end
            chk("prod", out_prod, q[0].prod);
            chk("iters", 64'(out_iters), 64'(q[0].iters));
            chk("in_ready_busy", 64'(in_ready), 64'd0);
            if (out_ready) begin
               void'(q.pop_front());
               seen = 1'b0;
            end
         end
      end
   end

   task automatic do_op(input logic [31:0] a, input logic [31:0] b, input int hold,
                        output logic [63:0] p, output logic [4:0] it);
      int   t;
      exp_t e;
      t = 0;
      while (!in_ready && t < 40) begin @(posedge clk); #2; t++; end
      chk("idle_in_ready", 64'(in_ready), 64'd1);
      in_a = a; in_b = b; in_valid = 1'b1;
      @(posedge clk); #1;
      e.prod  = model_prod(a, b);
      e.iters = 5'(model_n(a, b, 1'b1));
      e.e0    = cyc;
      q.push_back(e);
      #1;
      in_valid = 1'b0; in_a = $urandom; in_b = $urandom;
      t = 0;
      while (!out_valid && t < 40) begin @(posedge clk); #2; t++; end
      chk("out_valid_seen", 64'(out_valid), 64'd1);
      p  = out_prod;
      it = out_iters;
      for (int k = 0; k < hold; k++) begin
         in_valid = 1'b1; in_a = $urandom; in_b = $urandom;
         @(posedge clk); #2;
         chk("hold_in_ready", 64'(in_ready), 64'd0);
      end
      in_valid = 1'b0; out_ready = 1'b1;
      @(posedge clk); #2;
      out_ready = 1'b0;
      chk("post_hs_valid", 64'(out_valid), 64'd0);
      chk("post_hs_ready", 64'(in_ready), 64'd1);
   endtask

   task automatic do_op0(input logic [31:0] a, input logic [31:0] b,
                         output logic [63:0] p, output logic [4:0] it);
      int t, e0;
      chk("et0_idle_ready", 64'(in_ready0), 64'd1);
      in_a = a; in_b = b; in_valid0 = 1'b1;
      @(posedge clk); #1;
      e0 = cyc;
      #1 in_valid0 = 1'b0;
      t = 0;
      while (!out_valid0 && t < 40) begin @(posedge clk); #2; t++; end
      chk("et0_valid", 64'(out_valid0), 64'd1);
      chk("et0_latency", 64'(cyc), 64'(e0 + 17));
      chk("et0_prod", out_prod0, model_prod(a, b));
      chk("et0_iters", 64'(out_iters0), 64'(model_n(a, b, 1'b0)));
      p  = out_prod0;
      it = out_iters0;
      out_ready0 = 1'b1;
      @(posedge clk); #2;
      out_ready0 = 1'b0;
   endtask

   initial begin
      logic [63:0] p;
      logic [4:0]  it;

      #3 resetn = 1'b0;
      #1;
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_prod", out_prod, 64'd0);
      chk("rst_out_iters", 64'(out_iters), 64'd0);
      repeat (2) @(posedge clk);
      #2 resetn = 1'b1;

      do_op(32'd3, 32'd5, 0, p, it);
      chk("lit_3x5_prod", p, 64'd15);
      chk("lit_3x5_iters", 64'(it), 64'd2);

      do_op(32'hFFFFFFFF, 32'h7FFFFFFF, 0, p, it);
      chk("lit_m1_prod", p, 64'hFFFFFFFF80000001);
      chk("lit_m1_iters", 64'(it), 64'd1);

      do_op(32'h80000000, 32'h80000000, 0, p, it);
      chk("lit_min_prod", p, 64'h4000000000000000);
      chk("lit_min_iters", 64'(it), 64'd16);

      do_op(32'd5, 32'hFFFFFFFF, 0, p, it);
      chk("lit_swap_prod", p, 64'hFFFFFFFFFFFFFFFB);
      chk("lit_swap_iters", 64'(it), 64'd1);

      do_op(32'd1234, -32'sd77, 5, p, it);
      chk("lit_hold_prod", p, 64'hFFFFFFFFFFFE8CD6);
      chk("lit_hold_iters", 64'(it), 64'd4);

      do_op0(32'd7, -32'sd2, p, it);
      chk("lit_et0_prod", p, 64'hFFFFFFFFFFFFFFF2);
      chk("lit_et0_iters", 64'(it), 64'd16);

      // Abort an in-flight operation with an asynchronous reset.
      in_a = 32'h7FFFFFFF; in_b = 32'h7FFFFFF0; in_valid = 1'b1;
      @(posedge clk); #2 in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #2 resetn = 1'b0;
      #1;
      chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
      chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
      chk("mid_rst_out_prod", out_prod, 64'd0);
      chk("mid_rst_out_iters", 64'(out_iters), 64'd0);
      q.delete();
      seen = 1'b0;
      @(posedge clk); #2 resetn = 1'b1;
      repeat (20) @(posedge clk);
      #2 chk("abort_no_valid", 64'(out_valid), 64'd0);
      do_op(32'd2, 32'd3, 0, p, it);
      chk("after_rst_prod", p, 64'd6);

      for (int n = 0; n < 2500; n++)
         do_op(rnd_op(), rnd_op(), $urandom_range(0, 1), p, it);

      for (int n = 0; n < 6; n++)
         do_op0(rnd_op(), rnd_op(), p, it);

      repeat (3) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
